// File: rtl/fib_fir_mac.sv
// Serial-MAC FIR filter behind the Fibonacci generator: one shared multiplier, valid/ready on both sides.
// Optional build macro FIB_FIR_SAT_EN: saturate the shifted accumulator to DATA_W bits instead of wrapping.
module fib_fir_mac #(
   parameter int unsigned             DATA_W  = 16,
   parameter int unsigned             TAPS    = 4,
   parameter int unsigned             COEFF_W = 8,
   parameter logic [TAPS*COEFF_W-1:0] COEFFS  = 32'h01010101,
   parameter int unsigned             SHIFT   = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready
);

   localparam int unsigned IDX_W  = $clog2(TAPS);
   localparam int unsigned PROD_W = DATA_W + COEFF_W;
   localparam int unsigned ACC_W  = DATA_W + COEFF_W + $clog2(TAPS);

   typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

   state_t             state;
   logic [IDX_W-1:0]   idx;
   logic [ACC_W-1:0]   acc;
   logic [DATA_W-1:0]  x [TAPS];
   logic [COEFF_W-1:0] h [TAPS];
   logic [PROD_W-1:0]  prod_c;
   logic [ACC_W-1:0]   sum_c;
   logic [DATA_W-1:0]  red_c;

   for (genvar k = 0; k < TAPS; k++) begin : g_coef
      assign h[k] = COEFFS[k*COEFF_W +: COEFF_W];
   end

   // Single time-shared multiplier walking the taps
   assign prod_c = PROD_W'(h[idx]) * PROD_W'(x[idx]);
   assign sum_c  = acc + ACC_W'(prod_c);

`ifdef FIB_FIR_SAT_EN
   logic [ACC_W-1:0] shifted_c;
   assign shifted_c = sum_c >> SHIFT;
   assign red_c     = (|shifted_c[ACC_W-1:DATA_W]) ? {DATA_W{1'b1}} : shifted_c[DATA_W-1:0];
`else
   assign red_c = DATA_W'(sum_c >> SHIFT);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_data  <= '0;
         acc       <= '0;
         idx       <= '0;
         for (int k = 0; k < TAPS; k++) x[k] <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  x[0] <= in_data;
                  for (int k = 1; k < TAPS; k++) x[k] <= x[k-1];
                  acc      <= '0;
                  idx      <= '0;
                  in_ready <= 1'b0;
                  state    <= MAC;
               end
            end
            MAC: begin
               acc <= sum_c;
               if (idx == IDX_W'(TAPS - 1)) begin
                  out_data  <= red_c;
                  out_valid <= 1'b1;
                  state     <= OUT;
               end else begin
                  idx <= idx + IDX_W'(1);
               end
            end
            OUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state    <= IDLE;
               in_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule
